data_matrix_pc_ras: RTL and testbench

Parametrised program-counter unit for the LC-3 datapath: holds the PC, selects its next value from increment, bus, effective address or a hardware return-address stack (RAS), and exposes PC and PC-1 to the datapath. The RAS captures return addresses on JSR/JSRR/TRAP and supplies them on RET, with full/empty tracking and sticky error flags. It sits in the data matrix in place of the single-width, stack-less PC loader.

---
 rtl/data_matrix_pc_ras.sv | 157 +++++++++++++++
 tb/tb_data_matrix_pc_ras.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_matrix_pc_ras.sv
// data_matrix_pc_ras: LC-3 program counter with next-PC mux and an optional
// hardware return-address stack; the stack is built only when PC_RAS_EN is defined.
module data_matrix_pc_ras #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RST_VEC   = WIDTH'(16'h3000),
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic [WIDTH-1:0] ea,
  input  logic             ld_pc,
  input  logic [1:0]       pc_sel,
  input  logic             ras_push,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_minus_one,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_BUS = 2'b01;
  localparam logic [1:0] SEL_EA  = 2'b10;

  logic [WIDTH-1:0] reg_pc_q;
  logic [WIDTH-1:0] reg_pc_d;
  logic [WIDTH-1:0] ret_addr;
  logic             ret_valid;

  // Next-PC select; a return with no stacked address falls back to the bus (R7).
  always_comb begin
    reg_pc_d = reg_pc_q;
    if (ld_pc) begin
      case (pc_sel)
        SEL_INC: reg_pc_d = reg_pc_q + WIDTH'(1);
        SEL_BUS: reg_pc_d = bus;
        SEL_EA:  reg_pc_d = ea;
        default: reg_pc_d = ret_valid ? ret_addr : bus;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_pc_q <= RST_VEC;
    end else begin
      reg_pc_q <= reg_pc_d;
    end
  end

  assign pc           = reg_pc_q;
  assign pc_minus_one = reg_pc_q - WIDTH'(1);

`ifdef PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    wp_d;
  logic [PW-1:0]    wp_m1;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             pop;
  logic             empty;
  logic             full;

  assign pop   = ld_pc & (pc_sel == 2'b11);
  assign wp_m1 = wp_q - PW'(1);
  assign empty = (cnt_q == CW'(0));
  assign full  = (cnt_q == CW'(RAS_DEPTH));

  assign ret_valid = ~empty;
  assign ret_addr  = ras_mem_q[wp_m1];

  // Stack pointer/count update; a set of a sticky flag takes priority over err_clr.
  always_comb begin
    wp_d   = wp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q & ~err_clr;
    unf_d  = unf_q & ~err_clr;
    wr_en  = 1'b0;
    wr_idx = wp_q;
    if (ras_push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_idx = wp_m1;
    end else if (ras_push) begin
      wr_en = 1'b1;
      wp_d  = wp_q + PW'(1);
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (pop) begin
        unf_d = 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        wp_d  = wp_m1;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage is unreset; it is only ever read while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem_q[wr_idx] <= reg_pc_q;
    end
  end

  assign ras_top   = empty ? '0 : ras_mem_q[wp_m1];
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = ras_push ^ err_clr;
  assign ret_valid = 1'b0;
  assign ret_addr  = '0;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_data_matrix_pc_ras.sv
// Directed bench for data_matrix_pc_ras; exercises the RAS scenarios when
// PC_RAS_EN is defined and the stack-less behaviour otherwise.
module tb_data_matrix_pc_ras;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus;
  logic [15:0] ea;
  logic        ld_pc;
  logic [1:0]  pc_sel;
  logic        ras_push;
  logic        err_clr;
  logic [15:0] pc;
  logic [15:0] pc_minus_one;
  logic [15:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int checks;
  int errors;

  data_matrix_pc_ras dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ea           (ea),
    .ld_pc        (ld_pc),
    .pc_sel       (pc_sel),
    .ras_push     (ras_push),
    .err_clr      (err_clr),
    .pc           (pc),
    .pc_minus_one (pc_minus_one),
    .ras_top      (ras_top),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_ovf      (ras_ovf),
    .ras_unf      (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic ld, input logic [1:0] sel, input logic [15:0] b,
                       input logic [15:0] e, input logic push, input logic clr);
    ld_pc    = ld;
    pc_sel   = sel;
    bus      = b;
    ea       = e;
    ras_push = push;
    err_clr  = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    drive(1'b1, 2'b01, v, 16'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 16'h3000) begin errors++; $display("FAIL reset_pc got %h exp 3000", pc); end
    checks++; if (pc_minus_one !== 16'h2FFF) begin errors++; $display("FAIL reset_pcm1 got %h exp 2fff", pc_minus_one); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", ras_empty); end
    checks++; if (ras_top !== 16'h0) begin errors++; $display("FAIL reset_top got %h exp 0000", ras_top); end
    checks++; if ({ras_full, ras_ovf, ras_unf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ras_full, ras_ovf, ras_unf}); end
    rst_n = 1'b1;
  endtask

  task automatic test_increment();
    drive(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) step();
    checks++; if (pc !== 16'h3003) begin errors++; $display("FAIL inc_pc got %h exp 3003", pc); end
    checks++; if (pc_minus_one !== 16'h3002) begin errors++; $display("FAIL inc_pcm1 got %h exp 3002", pc_minus_one); end
  endtask

  task automatic test_hold();
    drive(1'b0, 2'b01, 16'hFFFF, 16'hEEEE, 1'b0, 1'b0);
    repeat (2) step();
    checks++; if (pc !== 16'h3003) begin errors++; $display("FAIL hold_pc got %h exp 3003", pc); end
  endtask

  task automatic test_bus_ea();
    drive(1'b1, 2'b01, 16'hABCD, 16'h5555, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'hABCD) begin errors++; $display("FAIL bus_pc got %h exp abcd", pc); end
    drive(1'b1, 2'b10, 16'h7777, 16'h1234, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL ea_pc got %h exp 1234", pc); end
    checks++; if (pc_minus_one !== 16'h1233) begin errors++; $display("FAIL ea_pcm1 got %h exp 1233", pc_minus_one); end
  endtask

  task automatic test_wrap();
    load_pc(16'hFFFF);
    checks++; if (pc_minus_one !== 16'hFFFE) begin errors++; $display("FAIL wrap_pre_pcm1 got %h exp fffe", pc_minus_one); end
    drive(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", pc); end
    checks++; if (pc_minus_one !== 16'hFFFF) begin errors++; $display("FAIL wrap_pcm1 got %h exp ffff", pc_minus_one); end
  endtask

`ifdef PC_RAS_EN
  task automatic test_call_return();
    load_pc(16'h3010);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    step();
    checks++; if (ras_top !== 16'h3010) begin errors++; $display("FAIL call_top got %h exp 3010", ras_top); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty got %b exp 0", ras_empty); end
    drive(1'b1, 2'b10, 16'h0, 16'h4000, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'h4000) begin errors++; $display("FAIL call_ea got %h exp 4000", pc); end
    drive(1'b1, 2'b11, 16'h9999, 16'h0, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'h3010) begin errors++; $display("FAIL ret_pc got %h exp 3010", pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b exp 1", ras_empty); end
    checks++; if (ras_top !== 16'h0) begin errors++; $display("FAIL ret_top got %h exp 0000", ras_top); end
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] exp_pc;
    for (int i = 1; i <= 5; i++) begin
      load_pc(16'(i));
      drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", ras_full); end
    checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ras_ovf); end
    checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL ovf_unf got %b exp 0", ras_unf); end
    checks++; if (ras_top !== 16'h0005) begin errors++; $display("FAIL ovf_top got %h exp 0005", ras_top); end
    for (int i = 0; i < 4; i++) begin
      exp_pc = 16'(5 - i);
      drive(1'b1, 2'b11, 16'hFFFF, 16'h0, 1'b0, 1'b0);
      step();
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL pop%0d_pc got %h exp %h", i, pc, exp_pc); end
      checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL pop%0d_full got %b exp 0", i, ras_full); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL pops_empty got %b exp 1", ras_empty); end
    drive(1'b1, 2'b11, 16'h1234, 16'h0, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL unf_pc got %h exp 1234", pc); end
    checks++; if (ras_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", ras_unf); end
    checks++; if (ras_ovf !== 1'b1) begin errors++; $display("FAIL unf_ovf_sticky got %b exp 1", ras_ovf); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL unf_empty got %b exp 1", ras_empty); end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    step();
    checks++; if ({ras_ovf, ras_unf} !== 2'b00) begin errors++; $display("FAIL clr_flags got %b exp 00", {ras_ovf, ras_unf}); end
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_push_pop_same();
    load_pc(16'h0A0A);
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    step();
    load_pc(16'h0B0B);
    drive(1'b1, 2'b11, 16'hFFFF, 16'h0, 1'b1, 1'b0);
    step();
    checks++; if (pc !== 16'h0A0A) begin errors++; $display("FAIL pp_pc got %h exp 0a0a", pc); end
    checks++; if (ras_top !== 16'h0B0B) begin errors++; $display("FAIL pp_top got %h exp 0b0b", ras_top); end
    checks++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b0000) begin errors++; $display("FAIL pp_flags got %b exp 0000", {ras_empty, ras_full, ras_ovf, ras_unf}); end
    drive(1'b1, 2'b11, 16'hFFFF, 16'h0, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'h0B0B) begin errors++; $display("FAIL pp_pop_pc got %h exp 0b0b", pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL pp_pop_empty got %b exp 1", ras_empty); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    repeat (3) step();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL ar_pre_empty got %b exp 0", ras_empty); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ar_empty got %b exp 1", ras_empty); end
    checks++; if (pc !== 16'h3000) begin errors++; $display("FAIL ar_pc got %h exp 3000", pc); end
    checks++; if (ras_top !== 16'h0) begin errors++; $display("FAIL ar_top got %h exp 0000", ras_top); end
    step();
    rst_n = 1'b1;
  endtask
`else
  task automatic test_no_ras();
    load_pc(16'h5555);
    drive(1'b1, 2'b11, 16'h2222, 16'h0, 1'b1, 1'b1);
    step();
    checks++; if (pc !== 16'h2222) begin errors++; $display("FAIL nr_ret_pc got %h exp 2222", pc); end
    checks++; if (ras_top !== 16'h0) begin errors++; $display("FAIL nr_top got %h exp 0000", ras_top); end
    checks++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000) begin errors++; $display("FAIL nr_flags got %b exp 1000", {ras_empty, ras_full, ras_ovf, ras_unf}); end
    drive(1'b1, 2'b11, 16'h3333, 16'h0, 1'b0, 1'b0);
    step();
    checks++; if (pc !== 16'h3333) begin errors++; $display("FAIL nr_ret2_pc got %h exp 3333", pc); end
    checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL nr_unf got %b exp 0", ras_unf); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 16'h3000) begin errors++; $display("FAIL ar_pc got %h exp 3000", pc); end
    checks++; if (pc_minus_one !== 16'h2FFF) begin errors++; $display("FAIL ar_pcm1 got %h exp 2fff", pc_minus_one); end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_increment();
    test_hold();
    test_bus_ea();
    test_wrap();
`ifdef PC_RAS_EN
    test_call_return();
    test_overflow_underflow();
    test_push_pop_same();
`else
    test_no_ras();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
